// File: rtl/anim_frame_player_if.sv
// Bundle between the frame player, the animation ROM and the matrix drivers.
// master = player side, slave = ROM/driver/control side.
interface anim_frame_player_if;
    logic        start;
    logic        enable;
    logic        loop;
    logic [3:0]  rom_addr;
    logic [63:0] rom_data;
    logic [7:0]  row_sel;
    logic [7:0]  col_data;
    logic [3:0]  frame_idx;
    logic        busy;
    logic        done;

    modport master (
        input  start,
        input  enable,
        input  loop,
        input  rom_data,
        output rom_addr,
        output row_sel,
        output col_data,
        output frame_idx,
        output busy,
        output done
    );

    modport slave (
        output start,
        output enable,
        output loop,
        output rom_data,
        input  rom_addr,
        input  row_sel,
        input  col_data,
        input  frame_idx,
        input  busy,
        input  done
    );
endinterface

// File: rtl/anim_frame_player.sv
// Sprite frame sequencer: loads 8x8 frames from ROM and row-scans an LED matrix.
// Define ANIM_PINGPONG_EN for a forward-then-backward frame sequence.
module anim_frame_player #(
    parameter int FRAME_COUNT = 5,
    parameter int FRAME_TICKS = 12_500_000,
    parameter int ROW_TICKS   = 50_000
) (
    input logic                 clk,
    input logic                 rst_n,
    anim_frame_player_if.master bus
);

    localparam int FW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int RW = (ROW_TICKS > 1) ? $clog2(ROW_TICKS) : 1;
    localparam logic [FW-1:0] FT_LAST = FW'(FRAME_TICKS - 1);
    localparam logic [RW-1:0] RT_LAST = RW'(ROW_TICKS - 1);
    localparam logic [3:0]    LAST    = 4'(FRAME_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHOW,
        DONE
    } state_t;

    state_t      state, state_n;
    logic [3:0]  idx, idx_n;
    logic [FW-1:0] ft, ft_n;
    logic [RW-1:0] rt, rt_n;
    logic [2:0]  row, row_n;
    logic [63:0] frame, frame_n;
    logic [63:0] shown;
    logic [7:0]  row_sel;
    logic [7:0]  col_data;
    logic        busy;
    logic        done;
    logic        scan;
    logic        lit;
`ifdef ANIM_PINGPONG_EN
    logic        dir, dir_n;
`endif

    assign bus.rom_addr  = idx;
    assign bus.frame_idx = idx;
    assign bus.row_sel   = row_sel;
    assign bus.col_data  = col_data;
    assign bus.busy      = busy;
    assign bus.done      = done;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        ft_n    = ft;
        rt_n    = rt;
        row_n   = row;
        frame_n = frame;
`ifdef ANIM_PINGPONG_EN
        dir_n   = dir;
`endif
        scan = (state == LOAD) || (state == SHOW);

        // Row scan free-runs across frame changes.
        if (scan) begin
            if (rt == RT_LAST) begin
                rt_n  = '0;
                row_n = row + 3'd1;
            end else begin
                rt_n = rt + RW'(1);
            end
        end

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = LOAD;
                    idx_n   = '0;
                    rt_n    = '0;
                    row_n   = '0;
`ifdef ANIM_PINGPONG_EN
                    dir_n   = 1'b0;
`endif
                end
            end
            LOAD: begin
                frame_n = bus.rom_data;
                ft_n    = '0;
                state_n = SHOW;
            end
            SHOW: begin
                if (bus.enable) begin
                    if (ft != FT_LAST) begin
                        ft_n = ft + FW'(1);
                    end else begin
                        state_n = LOAD;
`ifdef ANIM_PINGPONG_EN
                        if (FRAME_COUNT == 1) begin
                            if (!bus.loop) state_n = DONE;
                        end else if (!dir) begin
                            if (idx == LAST) begin
                                dir_n = 1'b1;
                                idx_n = LAST - 4'd1;
                            end else begin
                                idx_n = idx + 4'd1;
                            end
                        end else if (idx != 4'd0) begin
                            idx_n = idx - 4'd1;
                        end else if (bus.loop) begin
                            dir_n = 1'b0;
                            idx_n = 4'd1;
                        end else begin
                            state_n = DONE;
                        end
`else
                        if (idx != LAST) begin
                            idx_n = idx + 4'd1;
                        end else if (bus.loop) begin
                            idx_n = '0;
                        end else begin
                            state_n = DONE;
                        end
`endif
                    end
                end
            end
            DONE: begin
                frame_n = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // The LOAD cycle already drives the freshly read frame.
        shown = frame_n << {row, 3'b000};
        lit   = scan && ((state_n == LOAD) || (state_n == SHOW));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            ft       <= '0;
            rt       <= '0;
            row      <= '0;
            frame    <= '0;
            row_sel  <= '0;
            col_data <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef ANIM_PINGPONG_EN
            dir      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            ft       <= ft_n;
            rt       <= rt_n;
            row      <= row_n;
            frame    <= frame_n;
            row_sel  <= lit ? (8'd1 << row) : 8'd0;
            col_data <= lit ? shown[63:56] : 8'd0;
            busy     <= (state_n == LOAD) || (state_n == SHOW);
            done     <= (state_n == DONE);
`ifdef ANIM_PINGPONG_EN
            dir      <= dir_n;
`endif
        end
    end

endmodule
